// File: rtl/seq_shift_pkg.sv
// +----------------------------------------------------------------------+
// | seq_shift_pkg : shared mode and FSM state encodings for seq_shift_unit|
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

package seq_shift_pkg;

  localparam logic [1:0] MODE_LSL = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/seq_shift_unit_if.sv
// +----------------------------------------------------------------------+
// | seq_shift_if : control/data bundle for seq_shift_unit                 |
// | Optional sticky output present when SEQ_SHIFT_STICKY_EN is defined.   |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

interface seq_shift_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
);
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] data_in;
  logic             start;
  logic [1:0]       mode;
  logic [AMT_W-1:0] amount;
  logic [WIDTH-1:0] q;
  logic             shift_out;
  logic             busy;
  logic             done;
`ifdef SEQ_SHIFT_STICKY_EN
  logic             sticky;

  modport master (output clr, load, data_in, start, mode, amount,
                  input  q, shift_out, busy, done, sticky);
  modport slave  (input  clr, load, data_in, start, mode, amount,
                  output q, shift_out, busy, done, sticky);
`else
  modport master (output clr, load, data_in, start, mode, amount,
                  input  q, shift_out, busy, done);
  modport slave  (input  clr, load, data_in, start, mode, amount,
                  output q, shift_out, busy, done);
`endif
endinterface

`default_nettype wire

// File: rtl/seq_shift_unit_shift_step.sv
// +----------------------------------------------------------------------+
// | shift_step : combinational single-bit step for all four shift modes   |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module shift_step
  import seq_shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] q_next,
  output logic             out_bit
);

  always_comb begin
    q_next  = q;
    out_bit = q[0];
    case (mode)
      MODE_LSL: begin
        out_bit = q[WIDTH-1];
        q_next  = {q[WIDTH-2:0], 1'b0};
      end
      MODE_LSR: q_next = {1'b0, q[WIDTH-1:1]};
      MODE_ASR: q_next = {q[WIDTH-1], q[WIDTH-1:1]};
      default:  q_next = {q[0], q[WIDTH-1:1]};
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seq_shift_unit.sv
// +----------------------------------------------------------------------+
// | seq_shift_unit : operand register with multi-cycle LSL/LSR/ASR/ROR    |
// | engine, start/busy/done handshake. Macro: SEQ_SHIFT_STICKY_EN.        |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module seq_shift_unit
  import seq_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  seq_shift_if.slave bus
);

  localparam logic [AMT_W-1:0] c_width = AMT_W'(WIDTH);

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_q, w_q_next;
  logic             r_so, w_so_next;
  logic [1:0]       r_mode, w_mode_next;
  logic [AMT_W-1:0] r_cnt, w_cnt_next;
  logic [AMT_W-1:0] w_eff_cnt;
  logic [WIDTH-1:0] w_step_q;
  logic             w_step_out;
`ifdef SEQ_SHIFT_STICKY_EN
  logic             r_sticky, w_sticky_next;
`endif

  shift_step #(.WIDTH(WIDTH)) u_step (
    .q       (r_q),
    .mode    (r_mode),
    .q_next  (w_step_q),
    .out_bit (w_step_out)
  );

  // Rotations wrap; the other modes saturate at WIDTH so over-range fully flushes.
  always_comb begin
    w_eff_cnt = bus.amount;
    if (bus.mode == MODE_ROR)
      w_eff_cnt = bus.amount % c_width;
    else if (bus.amount > c_width)
      w_eff_cnt = c_width;
  end

  always_comb begin
    w_state_next = r_state;
    w_q_next     = r_q;
    w_so_next    = r_so;
    w_mode_next  = r_mode;
    w_cnt_next   = r_cnt;
`ifdef SEQ_SHIFT_STICKY_EN
    w_sticky_next = r_sticky;
`endif
    if (bus.clr) begin
      w_state_next = ST_IDLE;
      w_q_next     = '0;
      w_so_next    = 1'b0;
`ifdef SEQ_SHIFT_STICKY_EN
      w_sticky_next = 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.load) begin
            w_q_next = bus.data_in;
          end else if (bus.start) begin
            w_mode_next  = bus.mode;
            w_cnt_next   = w_eff_cnt;
            w_state_next = (w_eff_cnt == '0) ? ST_DONE : ST_SHIFT;
`ifdef SEQ_SHIFT_STICKY_EN
            w_sticky_next = 1'b0;
`endif
          end
        end
        ST_SHIFT: begin
          w_q_next   = w_step_q;
          w_so_next  = w_step_out;
          w_cnt_next = r_cnt - AMT_W'(1);
`ifdef SEQ_SHIFT_STICKY_EN
          w_sticky_next = r_sticky | w_step_out;
`endif
          if (r_cnt == AMT_W'(1))
            w_state_next = ST_DONE;
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_q     <= '0;
      r_so    <= 1'b0;
      r_mode  <= MODE_LSL;
      r_cnt   <= '0;
`ifdef SEQ_SHIFT_STICKY_EN
      r_sticky <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      r_q     <= w_q_next;
      r_so    <= w_so_next;
      r_mode  <= w_mode_next;
      r_cnt   <= w_cnt_next;
`ifdef SEQ_SHIFT_STICKY_EN
      r_sticky <= w_sticky_next;
`endif
    end
  end

  assign bus.q         = r_q;
  assign bus.shift_out = r_so;
  assign bus.busy      = (r_state == ST_SHIFT);
  assign bus.done      = (r_state == ST_DONE);
`ifdef SEQ_SHIFT_STICKY_EN
  assign bus.sticky    = r_sticky;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq_shift_unit.sv
// +----------------------------------------------------------------------+
// | tb_seq_shift_unit : directed scoreboard bench for seq_shift_unit      |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_seq_shift_unit;
  import seq_shift_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_shift_if #(.WIDTH(8), .AMT_W(4)) bus ();

  seq_shift_unit #(.WIDTH(8), .AMT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [7:0] q;
    logic       so;
    logic       st;
    int         cnt;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  logic model_so = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Arithmetic reference model built from whole-word operators.
  task automatic expect_op(input logic [7:0] v, input logic [1:0] m, input logic [3:0] a);
    exp_t        e;
    int          c;
    logic [15:0] lost;
    c     = (m == MODE_ROR) ? (int'(a) % 8) : ((a > 4'd8) ? 8 : int'(a));
    e.cnt = c;
    e.q   = v;
    e.so  = model_so;
    e.st  = 1'b0;
    if (c != 0) begin
      lost = ({8'h00, v} & ((16'h1 << c) - 16'h1));
      case (m)
        MODE_LSL: begin
          e.q  = v << c;
          e.so = v[8-c];
          lost = {8'h00, v} >> (8 - c);
        end
        MODE_LSR: begin
          e.q  = v >> c;
          e.so = v[c-1];
        end
        MODE_ASR: begin
          e.q  = 8'($signed(v) >>> c);
          e.so = v[c-1];
        end
        default: begin
          e.q  = (v >> c) | (v << (8 - c));
          e.so = v[c-1];
        end
      endcase
      e.st = |lost;
    end
    sb.push_back(e);
    model_so = e.so;
  endtask

  task automatic run_op(input logic [7:0] v, input logic [1:0] m, input logic [3:0] a,
                        input bit do_load, input bit poke, input string tag);
    exp_t e;
    int   lat;
    int   busy_cyc;
    if (do_load) begin
      bus.load    = 1'b1;
      bus.data_in = v;
      step();
      bus.load    = 1'b0;
    end
    expect_op(v, m, a);
    bus.start  = 1'b1;
    bus.mode   = m;
    bus.amount = a;
    step();
    bus.start  = 1'b0;
    bus.mode   = ~m;
    bus.amount = 4'hF;
    lat      = 1;
    busy_cyc = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      if (bus.busy === 1'b1) busy_cyc++;
      if (poke && lat == 1) begin
        bus.load    = 1'b1;
        bus.data_in = 8'h00;
        bus.start   = 1'b1;
      end
      step();
      bus.load  = 1'b0;
      bus.start = 1'b0;
      lat++;
    end
    e = sb.pop_front();
    chk({tag, "_latency"}, lat, e.cnt + 1);
    chk({tag, "_busy_cycles"}, busy_cyc, e.cnt);
    chk({tag, "_q"}, bus.q, e.q);
    chk({tag, "_shift_out"}, bus.shift_out, e.so);
`ifdef SEQ_SHIFT_STICKY_EN
    chk({tag, "_sticky"}, bus.sticky, e.st);
`endif
    step();
    chk({tag, "_done_one_cycle"}, {bus.done, bus.busy}, 2'b00);
  endtask

  initial begin
    bit seen_done;
    rst         = 1'b1;
    bus.clr     = 1'b0;
    bus.load    = 1'b0;
    bus.data_in = 8'h00;
    bus.start   = 1'b0;
    bus.mode    = MODE_LSL;
    bus.amount  = 4'd0;
    step();
    step();
    rst = 1'b0;
    chk("reset_q", bus.q, 8'h00);
    chk("reset_shift_out", bus.shift_out, 1'b0);
    chk("reset_busy_done", {bus.busy, bus.done}, 2'b00);
`ifdef SEQ_SHIFT_STICKY_EN
    chk("reset_sticky", bus.sticky, 1'b0);
`endif

    run_op(8'hF5, MODE_ASR, 4'd3, 1'b1, 1'b0, "asr3");
    chk("asr3_literal", bus.q, 8'hFE);
    run_op(8'hF5, MODE_LSR, 4'd3, 1'b1, 1'b1, "lsr3_poked");
    chk("lsr3_literal", bus.q, 8'h1E);
    run_op(8'hF5, MODE_LSL, 4'd2, 1'b1, 1'b0, "lsl2");
    chk("lsl2_literal", bus.q, 8'hD4);
    run_op(8'hF5, MODE_ROR, 4'd11, 1'b1, 1'b0, "ror11");
    chk("ror11_literal", bus.q, 8'hBE);
    run_op(8'hBE, MODE_ROR, 4'd0, 1'b0, 1'b0, "amt0");
    run_op(8'hF5, MODE_LSR, 4'd15, 1'b1, 1'b0, "lsr15");
    run_op(8'h80, MODE_ASR, 4'd15, 1'b1, 1'b0, "asr15");
    chk("asr15_literal", bus.q, 8'hFF);
    run_op(8'hF5, MODE_LSL, 4'd9, 1'b1, 1'b0, "lsl9");
    run_op(8'h05, MODE_LSR, 4'd2, 1'b1, 1'b0, "lsr2_lost");
    run_op(8'h04, MODE_LSR, 4'd2, 1'b1, 1'b0, "lsr2_clean");
    run_op(8'hA6, MODE_ROR, 4'd7, 1'b1, 1'b0, "ror7");

    // Abort by clr after two shift steps.
    bus.load = 1'b1; bus.data_in = 8'hF5; step(); bus.load = 1'b0;
    bus.start = 1'b1; bus.mode = MODE_LSR; bus.amount = 4'd5; step(); bus.start = 1'b0;
    step();
    step();
    bus.clr = 1'b1; step(); bus.clr = 1'b0;
    model_so = 1'b0;
    chk("clr_q", bus.q, 8'h00);
    chk("clr_busy", bus.busy, 1'b0);
    chk("clr_shift_out", bus.shift_out, 1'b0);
    seen_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.done === 1'b1) seen_done = 1'b1;
      step();
    end
    chk("clr_no_done", seen_done, 1'b0);

    // Reset mid-operation.
    bus.load = 1'b1; bus.data_in = 8'hF5; step(); bus.load = 1'b0;
    bus.start = 1'b1; bus.mode = MODE_LSR; bus.amount = 4'd5; step(); bus.start = 1'b0;
    step();
    step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_mid_q", bus.q, 8'h00);
    chk("rst_mid_flags", {bus.shift_out, bus.busy, bus.done}, 3'b000);
`ifdef SEQ_SHIFT_STICKY_EN
    chk("rst_mid_sticky", bus.sticky, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_shift_unit.md
Name: seq_shift_unit

Overview:
- Parametrised successor to the team's single-mode shift register: a WIDTH-bit operand register with parallel load and a multi-cycle shift engine.
- Supports logical left, logical right, arithmetic right and rotate right by a programmable amount, one bit per clock.
- Uses a start/busy/done handshake.
- Sits beside the sequential multiplier/ALU datapath as its shift/normalise resource.

Parameters:
- WIDTH, 8, operand and register width in bits (>=2)
- AMT_W, 4, width of the shift-amount input; must satisfy 2**AMT_W > WIDTH

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- clr  input  1  synchronous clear of the register; aborts any operation
- load  input  1  parallel load of data_in into q (IDLE only)
- data_in  input  WIDTH  parallel load value
- start  input  1  begin shift operation (IDLE only)
- mode  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR; sampled with start
- amount  input  AMT_W  shift distance; sampled with start
- q  output  WIDTH  register contents
- shift_out  output  1  last bit shifted/rotated out
- busy  output  1  high while shifting
- done  output  1  single-cycle completion pulse

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset values: q=0, shift_out=0, busy=0, done=0, state IDLE.
- Priority each edge: rst > clr > load > start.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - load=1 -> q<=data_in; shift_out unchanged.
  - Else start=1 -> latch mode and effective count cnt.
  - cnt=0 -> go to DONE; else go to SHIFT.
- Effective count:
  - LSL/LSR/ASR: cnt = min(amount, WIDTH). Over-range saturates: LSL/LSR result 0, ASR result all sign bits.
  - ROR: cnt = amount mod WIDTH.
- SHIFT: each edge performs one 1-bit step of the latched mode, updates shift_out and decrements cnt. After the final step go to DONE.
  - LSL: shift_out<=q[WIDTH-1]; q<={q[WIDTH-2:0],0}.
  - LSR: shift_out<=q[0]; zero fill at the MSB.
  - ASR: shift_out<=q[0]; q[WIDTH-1] replicated.
  - ROR: shift_out<=q[0]; q<={q[0],q[WIDTH-1:1]}.
- DONE: done=1 for exactly one cycle, then IDLE.
- busy is high exactly in SHIFT.
- Latency: done is asserted cnt+1 cycles after the start edge; cnt=0 gives done 1 cycle after start with q unchanged.
- load or start while in SHIFT or DONE is ignored (not queued); mode/amount changes mid-operation have no effect.
- clr in any state: q<=0, shift_out<=0, go to IDLE next edge, no done pulse.
- rst mid-operation behaves identically to clr plus full reset values.
- q is registered; it is valid and stable in IDLE and DONE.

Optional Feature:
- Macro SEQ_SHIFT_STICKY_EN.
- Defined:
  - Extra output sticky (1 bit), reset 0, cleared on an accepted start and by clr.
  - In SHIFT, sticky <= sticky | bit shifted out. It ORs all bits lost, for rounding; for ROR it is still computed.
  - Valid when done is high.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package seq_shift_pkg:
  - mode encodings MODE_LSL/MODE_LSR/MODE_ASR/MODE_ROR
  - FSM state encodings ST_IDLE/ST_SHIFT/ST_DONE
- One natural sub-module: shift_step. Combinational, parameter WIDTH; inputs q and mode; outputs next q and out-bit. Instantiated once by the FSM/counter top.

Test Plan (WIDTH=8, AMT_W=4):
- Load 8'b11110101; start ASR amount 3 -> busy 3 cycles; done on 4th cycle after start; q=8'b11111110, shift_out=1.
- Load 8'b11110101; LSR 3 -> q=8'b00011110, shift_out=1. Then load again; LSL 2 -> q=8'b11010100, shift_out=1.
- Load 8'b11110101; ROR amount 11 -> 3 cycles busy; q=8'b10111110. Then amount 0 -> no busy; done 1 cycle after start; q unchanged.
- Load 8'b11110101; LSR amount 15 -> busy 8 cycles; q=0, shift_out=1. ASR 15 on 8'b10000000 -> q=8'hFF.
- Start LSR 5 on 8'hF5; assert clr after 2 shifts -> q=0, busy=0 next cycle, done never pulses. load/start pulsed during busy are ignored.
- With SEQ_SHIFT_STICKY_EN: 8'b00000101 LSR 2 -> sticky=1; 8'b00000100 LSR 2 -> sticky=0; rst mid-shift -> all outputs 0.
